// File: rtl/opl3_pkg.sv
// Shared opl3 definitions: operator count and the slot-reader sweep states.
package opl3_pkg;

  localparam int unsigned NUM_OPERATORS = 36;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } slot_rd_state_t;

endpackage

// File: rtl/op_slot_skid_buf.sv
// Small in-order buffer that absorbs RAM read data while downstream stalls.
module op_slot_skid_buf #(
  parameter int unsigned depth = 2,
  parameter int unsigned width = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [width-1:0]             din,
  output logic [width-1:0]             dout,
  output logic                         empty,
  output logic [$clog2(depth+1)-1:0]   count
);

  localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CW = $clog2(depth + 1);

  logic [width-1:0] mem [depth];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction

  assign do_pop = pop && !empty;
  assign empty  = (count == '0);
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < depth; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= next_ptr(wr_ptr);
      end
      if (do_pop) rd_ptr <= next_ptr(rd_ptr);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue throttling upstream must keep the buffer from ever being written while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (reset) push |-> (count != CW'(depth)))
    else $error("op_slot_skid_buf: write to full buffer");

endmodule

// File: rtl/op_slot_reader.sv
// Sweeps all operator slot words out of a simple-dual-port RAM once per sample tick.
// Optional OP_SLOT_READER_OVERRUN_EN builds the sticky tick-while-busy overrun flag.
module op_slot_reader
  import opl3_pkg::*;
#(
  parameter int unsigned NUM_SLOTS    = NUM_OPERATORS,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned OUTPUT_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sample_clk_en,
  output logic                          ram_reb,
  output logic [$clog2(NUM_SLOTS)-1:0]  ram_addrb,
  input  logic [DATA_WIDTH-1:0]         ram_dob,
  output logic [DATA_WIDTH-1:0]         slot_data,
  output logic [$clog2(NUM_SLOTS)-1:0]  slot_num,
  output logic                          slot_valid,
  input  logic                          slot_ready,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  localparam int unsigned AW    = $clog2(NUM_SLOTS);
  localparam int unsigned DEPTH = OUTPUT_DELAY + 1;
  localparam int unsigned CW    = $clog2(DEPTH + 1);
  localparam int unsigned OW    = 4;

  if (OUTPUT_DELAY != 1 && OUTPUT_DELAY != 2) begin : g_bad_delay
    $fatal(1, "op_slot_reader: OUTPUT_DELAY must be 1 or 2");
  end

  slot_rd_state_t         state;
  logic [AW-1:0]          cnt;
  logic [AW-1:0]          addr_q;
  logic [OUTPUT_DELAY-1:0] pipe_v;
  logic [AW-1:0]          pipe_tag [OUTPUT_DELAY];
  logic [OW-1:0]          in_flight;
  logic                   issue;
  logic                   pop_now;
  logic                   last_pop;
  logic [CW-1:0]          buf_count;
  logic                   buf_empty;
  logic [AW+DATA_WIDTH-1:0] buf_dout;

  always_comb begin
    in_flight = '0;
    for (int unsigned i = 0; i < OUTPUT_DELAY; i++) in_flight = in_flight + OW'(pipe_v[i]);
  end

  // Issue only while every outstanding word is guaranteed a buffer slot.
  assign pop_now  = slot_valid && slot_ready;
  assign issue    = (state == READ) &&
                    ((in_flight + OW'(buf_count)) < (OW'(DEPTH) + OW'(pop_now)));
  assign last_pop = pop_now && (slot_num == AW'(NUM_SLOTS - 1));

  assign ram_reb    = issue;
  assign ram_addrb  = issue ? cnt : addr_q;
  assign busy       = (state != IDLE);
  assign done       = (state == DRAIN) && last_pop;
  assign slot_valid = !buf_empty;
  assign {slot_num, slot_data} = buf_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      pipe_v <= '0;
      for (int unsigned i = 0; i < OUTPUT_DELAY; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_v[0]   <= issue;
      pipe_tag[0] <= cnt;
      for (int unsigned i = 1; i < OUTPUT_DELAY; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
      case (state)
        IDLE: begin
          if (sample_clk_en) begin
            state <= READ;
            cnt   <= '0;
          end
        end
        READ: begin
          if (issue) begin
            addr_q <= cnt;
            if (cnt == AW'(NUM_SLOTS - 1)) state <= DRAIN;
            else                           cnt   <= cnt + AW'(1);
          end
        end
        DRAIN: begin
          if (last_pop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef OP_SLOT_READER_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (reset)                                overrun <= 1'b0;
    else if (sample_clk_en && state != IDLE) overrun <= 1'b1;
  end
`else
  assign overrun = 1'b0;
`endif

  op_slot_skid_buf #(
    .depth (DEPTH),
    .width (AW + DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .reset (reset),
    .push  (pipe_v[OUTPUT_DELAY-1]),
    .pop   (pop_now),
    .din   ({pipe_tag[OUTPUT_DELAY-1], ram_dob}),
    .dout  (buf_dout),
    .empty (buf_empty),
    .count (buf_count)
  );

endmodule

// File: tb/tb_op_slot_reader.sv
// Bench for op_slot_reader: read latencies 1 and 2 side by side against a slot-count reference model.
module tb_op_slot_reader;

  localparam int N = 36;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sample_clk_en = 1'b0;
  logic        ready = 1'b1;
  logic [31:0] mem [N];
  int          cyc = 0;
  int          t0 = 0;
  bit          timing_mode = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = g + 1;

    logic        reb, done, busy, valid, ovr;
    logic [5:0]  addrb, num;
    logic [31:0] data, dob, r1;

    op_slot_reader #(.NUM_SLOTS(N), .DATA_WIDTH(32), .OUTPUT_DELAY(D)) u_dut (
      .clk           (clk),
      .reset         (reset),
      .sample_clk_en (sample_clk_en),
      .ram_reb       (reb),
      .ram_addrb     (addrb),
      .ram_dob       (dob),
      .slot_data     (data),
      .slot_num      (num),
      .slot_valid    (valid),
      .slot_ready    (ready),
      .busy          (busy),
      .done          (done),
      .overrun       (ovr)
    );

    // RAM with D cycles of read latency
    if (D == 1) begin : g_ram1
      always @(posedge clk) if (reb) dob <= mem[addrb];
    end else begin : g_ram2
      always @(posedge clk) begin
        if (reb) r1 <= mem[addrb];
        dob <= r1;
      end
    end

    // Reference model: counts of issued and delivered slots per sweep
    bit          busy_m = 0, ov_m = 0, just_reset = 0, prev_stall = 0;
    int          exp_idx = 0, n_reb = 0, last_addr = 0;
    logic [5:0]  prev_num;
    logic [31:0] prev_data;

    always @(negedge clk) begin
      bit pop;
      bit exp_reb;
      int outst;
      if (reset) begin
        busy_m = 0; ov_m = 0; exp_idx = 0; n_reb = 0; last_addr = 0;
        prev_stall = 0; just_reset = 1;
      end else begin
        if (just_reset) begin
          check("rst_valid", valid, 0);
          check("rst_data", data, 0);
          check("rst_num", num, 0);
          check("rst_reb", reb, 0);
          check("rst_addr", addrb, 0);
          check("rst_done", done, 0);
          check("rst_overrun", ovr, 0);
          just_reset = 0;
        end
        check("busy", busy, busy_m);
        check("overrun", ovr, ov_m);
        pop     = valid && ready;
        outst   = n_reb - exp_idx;
        exp_reb = busy_m && (n_reb < N) && (outst - int'(pop) < D + 1);
        check("ram_reb", reb, exp_reb);
        if (reb) begin
          check("ram_addrb", addrb, n_reb);
          last_addr = n_reb;
          n_reb++;
        end else begin
          check("addr_hold", addrb, last_addr);
        end
        if (prev_stall) begin
          check("hold_valid", valid, 1);
          check("hold_num", num, prev_num);
          check("hold_data", data, prev_data);
        end
        if (pop) begin
          check("spurious", busy_m, 1);
          if (exp_idx >= N) begin
            check("extra_word", exp_idx, N - 1);
          end else begin
            check("slot_num", num, exp_idx);
            check("slot_data", data, mem[exp_idx]);
            if (timing_mode) check("latency", cyc - t0, 2 + D + exp_idx);
            check("done", done, exp_idx == N - 1);
          end
          exp_idx++;
        end else begin
          check("done_idle", done, 0);
        end
        prev_stall = valid && !ready;
        prev_num   = num;
        prev_data  = data;
`ifdef OP_SLOT_READER_OVERRUN_EN
        if (sample_clk_en && busy_m) ov_m = 1;
`endif
        if (!busy_m && sample_clk_en) begin
          busy_m = 1; exp_idx = 0; n_reb = 0;
        end else if (pop && exp_idx == N) begin
          busy_m = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready held high, 1: ready low in cycles 5..14, 2: random ready
  task automatic run_sweep(input int mode, input int tick2, input int rst_at);
    int rel;
    bit fin;
    timing_mode   = (mode == 0);
    sample_clk_en = 1'b1;
    ready         = 1'b1;
    t0            = cyc;
    rel           = 0;
    fin           = 0;
    while (!fin && rel < 300) begin
      step();
      rel           = cyc - t0;
      sample_clk_en = (rel == tick2);
      reset         = (rel == rst_at);
      case (mode)
        1:       ready = !(rel >= 5 && rel <= 14);
        2:       ready = ($urandom_range(0, 9) < 7);
        default: ready = 1'b1;
      endcase
      if (rel > 2 && !g_dut[0].busy_m && !g_dut[1].busy_m && !sample_clk_en && !reset) fin = 1;
    end
    check("sweep_finished", fin, 1);
    sample_clk_en = 1'b0;
    reset         = 1'b0;
    ready         = 1'b1;
    step();
  endtask

  initial begin
    for (int k = 0; k < N; k++) mem[k] = 32'(k * 3);
    repeat (3) step();
    reset = 1'b0;
    repeat (2) step();

    run_sweep(0, -1, -1);
    check("count_d1", g_dut[0].exp_idx, N);
    check("count_d2", g_dut[1].exp_idx, N);

    run_sweep(0, 10, -1);
    run_sweep(1, -1, -1);
    check("stall_count_d1", g_dut[0].exp_idx, N);
    check("stall_count_d2", g_dut[1].exp_idx, N);

    for (int s = 0; s < 4; s++) begin
      for (int k = 0; k < N; k++) mem[k] = $urandom;
      run_sweep(2, int'($urandom_range(3, 45)), -1);
      check("rand_count_d1", g_dut[0].exp_idx, N);
      check("rand_count_d2", g_dut[1].exp_idx, N);
    end

    run_sweep(0, -1, 20);
    run_sweep(0, -1, -1);
    check("post_rst_count_d1", g_dut[0].exp_idx, N);
    check("post_rst_count_d2", g_dut[1].exp_idx, N);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/op_slot_reader.md
OP_SLOT_READER -- requirements
Module: op_slot_reader

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 36, number of operator slots swept per sample tick.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, width of one slot register word.
REQ-003 SHALL have parameter OUTPUT_DELAY, default 1, read latency of the attached simple-dual-port RAM; legal values 1 or 2.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port sample_clk_en, input, 1, one-cycle pulse that starts a sweep.
REQ-007 SHALL have port ram_reb, output, 1, RAM read enable.
REQ-008 SHALL have port ram_addrb, output, $clog2(NUM_SLOTS), RAM read address.
REQ-009 SHALL have port ram_dob, input, DATA_WIDTH, RAM read data.
REQ-010 SHALL have port slot_data, output, DATA_WIDTH, delivered word.
REQ-011 SHALL have port slot_num, output, $clog2(NUM_SLOTS), slot index of slot_data.
REQ-012 SHALL have port slot_valid, output, 1, slot_data/slot_num valid.
REQ-013 SHALL have port slot_ready, input, 1, downstream accepts; transfer on slot_valid && slot_ready.
REQ-014 SHALL have ports busy, output, 1 (sweep in progress) and done, output, 1 (one-cycle end-of-sweep pulse).
REQ-015 SHALL have port overrun, output, 1, sticky tick-while-busy flag.

Function
REQ-016 SHALL implement states IDLE, READ, DRAIN; busy = (state != IDLE).
REQ-017 IDLE + sample_clk_en SHALL go to READ next cycle, read address counter = 0.
REQ-018 READ SHALL drive ram_reb=1, ram_addrb=counter when issue allowed; counter increments per issue; issue of slot NUM_SLOTS-1 SHALL go to DRAIN.
REQ-019 Issue allowed iff in_flight + buf_count - pop_now < OUTPUT_DELAY+1, pop_now = slot_valid && slot_ready this cycle.
REQ-020 ram_reb SHALL be 0 and ram_addrb SHALL hold its last value whenever no issue occurs.
REQ-021 Each issue SHALL enter an OUTPUT_DELAY-deep tag pipe; after OUTPUT_DELAY cycles ram_dob and tag SHALL be written into an (OUTPUT_DELAY+1)-entry in-order buffer.
REQ-022 slot_valid SHALL equal buffer non-empty; slot_data/slot_num SHALL be the buffer head and stay stable while slot_valid && !slot_ready.
REQ-023 With slot_ready held 1, sample_clk_en in cycle 0 SHALL give ram_reb in cycles 1..NUM_SLOTS, slot_num k valid in cycle 2+OUTPUT_DELAY+k, zero bubbles.
REQ-024 done SHALL pulse in the cycle slot NUM_SLOTS-1 transfers; state returns to IDLE the next cycle.
REQ-025 sample_clk_en while busy SHALL NOT restart or alter the sweep.
REQ-026 The buffer SHALL never overflow; a write to a full buffer is a design error (assertion).
REQ-027 OUTPUT_DELAY outside {1,2} SHALL cause an elaboration-time fatal.

Reset
REQ-028 reset SHALL force IDLE, clear counter, tag pipe, buffer, and overrun, overriding all other inputs that cycle.
REQ-029 Reset values: ram_reb=0, ram_addrb=0, slot_valid=0, slot_data=0, slot_num=0, busy=0, done=0, overrun=0.
REQ-030 Reset mid-sweep SHALL discard in-flight reads; no stale word is delivered after reset deasserts.

Configuration
REQ-031 Macro OP_SLOT_READER_OVERRUN_EN defined: overrun SHALL set in the cycle after sample_clk_en arrives while busy and hold until reset.
REQ-032 Macro undefined: overrun SHALL be constant 0 and no detection logic built; REQ-025 still holds.

Structure
REQ-033 State enum and NUM_OPERATORS constant (36) SHALL live in the shared opl3 package.
REQ-034 The in-order buffer SHALL be sub-module op_slot_skid_buf (parameters depth, width; ports push, pop, din, dout, empty, count).

Verification
REQ-035 OUTPUT_DELAY=1, ready=1, RAM[k]=k*3, tick cycle 0 -> slot k valid cycle 3+k with data 3k, done cycle 38, busy low cycle 39.
REQ-036 OUTPUT_DELAY=2, ready=1 -> slot 0 valid cycle 4, slot 35 cycle 39, no bubbles.
REQ-037 ready low cycles 5..14 -> slot_data/slot_num frozen, ram_reb low once buffer+in-flight = OUTPUT_DELAY+1, all 36 slots delivered in order exactly once.
REQ-038 Second tick at cycle 10 with macro defined -> sweep unaffected, overrun=1 from cycle 11; without macro overrun stays 0.
REQ-039 reset at cycle 20 mid-sweep -> cycle 21 all outputs at reset values; new tick yields full sweep starting at slot 0.
